// File: rtl/fib_gen_pkg.sv
// Shared types and constants for the Fibonacci stream generators.
package fib_gen_pkg;

    typedef enum logic [1:0] {IDLE, RUN, TERM} state_t;

    // mode[1:0]: which terms are emitted
    localparam logic [1:0] FILT_ALL  = 2'd0;
    localparam logic [1:0] FILT_ODD  = 2'd1;
    localparam logic [1:0] FILT_EVEN = 2'd2;

    // mode[2]: how the run is bounded
    localparam logic BOUND_VAL = 1'b0;
    localparam logic BOUND_CNT = 1'b1;

    // Parity filter; code 3 behaves like FILT_ALL.
    function automatic logic filt_pass(input logic [1:0] filt, input logic lsb);
        case (filt)
            FILT_ALL:  return 1'b1;
            FILT_ODD:  return lsb;
            FILT_EVEN: return !lsb;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/fib_out_reg.sv
// Output holding register for valid/ready stream sources.
// A beat is held stable until consumed; when free and nothing is loaded the
// register empties.
module fib_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             ld_done,
    input  logic             ld_error,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ready,
    output logic             valid,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    // Free when empty or the current beat is handed off this cycle.
    assign free = !valid || ready;

    // Load a new beat, drop an accepted one, or hold while stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            data  <= '0;
        end else if (free) begin
            if (load) begin
                valid <= 1'b1;
                done  <= ld_done;
                error <= ld_error;
                data  <= ld_data;
            end else begin
                valid <= 1'b0;
                done  <= 1'b0;
                error <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fib_stream_gen.sv
// Fibonacci stream source: value- or count-bounded runs with a parity filter,
// full backpressure and a terminal beat that reports count-mode overflow.
module fib_stream_gen
    import fib_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [2:0]       mode,
    input  logic             ready,
    output logic             valid,
    output logic             done,
    output logic [WIDTH-1:0] out_0,
    output logic             error,
    output logic             busy
);

    state_t           state, state_d;
    logic [WIDTH-1:0] n_q, a, b;
    logic [2:0]       mode_q;
    logic             a_ovf, b_ovf;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   sum;
    logic             free, load, ld_done, ld_error, capture, advance;
    logic [WIDTH-1:0] ld_data;
    logic             pass, val_end, cnt_end, end_run, run_err;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign pass = filt_pass(mode_q[1:0], a[0]);
    assign busy = (state != IDLE);

    // Once a has overflowed its true value exceeds any n, so the wrapped a is
    // never compared in value mode.
    assign val_end = a_ovf || (a >= n_q);
    assign cnt_end = (count == CNT_W'(n_q)) || a_ovf;
    assign end_run = (mode_q[2] == BOUND_VAL) ? val_end : cnt_end;
    assign run_err = (mode_q[2] == BOUND_CNT) && a_ovf && (count != CNT_W'(n_q));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next state and per-cycle engine controls; one evaluation per free cycle.
    always_comb begin
        state_d  = state;
        capture  = 1'b0;
        advance  = 1'b0;
        load     = 1'b0;
        ld_done  = 1'b0;
        ld_error = 1'b0;
        ld_data  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (free) begin
                    if (end_run) begin
                        load     = 1'b1;
                        ld_done  = 1'b1;
                        ld_error = run_err;
                        state_d  = TERM;
                    end else begin
                        advance = 1'b1;
                        if (pass) begin
                            load    = 1'b1;
                            ld_data = a;
                        end
                    end
                end
            end
            TERM: begin
                if (valid && ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Run parameters and sequence registers; overflow flags are sticky along
    // the sequence so a_ovf marks any term whose true value needs > WIDTH bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_q    <= '0;
            mode_q <= '0;
            a      <= '0;
            b      <= WIDTH'(1);
            a_ovf  <= 1'b0;
            b_ovf  <= 1'b0;
            count  <= '0;
        end else if (capture) begin
            n_q    <= n;
            mode_q <= mode;
            a      <= '0;
            b      <= WIDTH'(1);
            a_ovf  <= 1'b0;
            b_ovf  <= 1'b0;
            count  <= '0;
        end else if (advance) begin
            a     <= b;
            b     <= sum[WIDTH-1:0];
            a_ovf <= b_ovf;
            b_ovf <= sum[WIDTH] | a_ovf | b_ovf;
            if (pass) count <= count + CNT_W'(1);
        end
    end

    fib_out_reg #(.WIDTH(WIDTH)) u_out (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .ld_done  (ld_done),
        .ld_error (ld_error),
        .ld_data  (ld_data),
        .ready    (ready),
        .valid    (valid),
        .done     (done),
        .error    (error),
        .data     (out_0),
        .free     (free)
    );

endmodule

// File: tb/tb_fib_stream_gen.sv
// Bench for fib_stream_gen: a 32-bit and an 8-bit instance checked against a
// Fibonacci reference built with wide plain arithmetic.
module tb_fib_stream_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [31:0] n = '0;
    logic [2:0]  mode = '0;
    logic        ready = 1'b0;

    logic        valid32, done32, error32, busy32;
    logic [31:0] out32;
    logic        valid8, done8, error8, busy8;
    logic [7:0]  out8;

    int errors = 0;
    int checks = 0;

    bit          sel8 = 1'b0;
    logic        sv, sd, se, sb;
    logic [31:0] so;

    longint unsigned exp_q[$];
    bit              exp_pat[$];
    bit              exp_err;

    always #5 clock = ~clock;

    fib_stream_gen #(.WIDTH(32), .CNT_W(32)) d32 (
        .clock(clock), .reset(reset), .start(start32), .n(n), .mode(mode),
        .ready(ready), .valid(valid32), .done(done32), .out_0(out32),
        .error(error32), .busy(busy32)
    );

    fib_stream_gen #(.WIDTH(8), .CNT_W(8)) d8 (
        .clock(clock), .reset(reset), .start(start8), .n(n[7:0]), .mode(mode),
        .ready(ready), .valid(valid8), .done(done8), .out_0(out8),
        .error(error8), .busy(busy8)
    );

    always_comb begin
        sv = sel8 ? valid8 : valid32;
        sd = sel8 ? done8  : done32;
        se = sel8 ? error8 : error32;
        sb = sel8 ? busy8  : busy32;
        so = sel8 ? {24'b0, out8} : out32;
    end

    // Reference: true Fibonacci terms; a term overflows when it reaches 2^w.
    // exp_pat is the per-cycle valid pattern with ready held high, ending in
    // the terminal beat.
    function automatic void build_model(input int w, input longint unsigned nn,
                                        input logic [2:0] md);
        longint unsigned x, y, t, lim;
        longint unsigned cnt;
        bit p;
        x = 0; y = 1; cnt = 0;
        lim = 64'd1 << w;
        exp_q.delete();
        exp_pat.delete();
        exp_err = 1'b0;
        for (int g = 0; g < 200; g++) begin
            if (md[2]) begin
                if (cnt == nn) break;
                if (x >= lim) begin exp_err = 1'b1; break; end
            end else if (x >= nn) break;
            p = (md[1:0] == 2'd1) ? x[0] : (md[1:0] == 2'd2) ? !x[0] : 1'b1;
            exp_pat.push_back(p);
            if (p) begin exp_q.push_back(x); cnt++; end
            t = x + y; x = y; y = t;
        end
        exp_pat.push_back(1'b1);
    endfunction

    function automatic logic next_ready(input int rmode, input int k);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return ($urandom_range(0, 2) != 0);
    endfunction

    // One complete run; rmode 0 = ready high, 1 = 1,0,0,1 pattern, 2 = random.
    // poke != 0 pulses start (with other n/mode) during the run at that cycle.
    task automatic run_stream(input bit w8, input longint unsigned nn,
                              input logic [2:0] md, input int rmode, input int poke);
        int cyc = 0, idx = 0, k = 0;
        bit held = 0, term = 0;
        logic [31:0] pout = '0;
        logic pdone = 1'b0, perr = 1'b0;
        sel8 = w8;
        build_model(w8 ? 8 : 32, nn, md);
        @(negedge clock);
        n = nn[31:0]; mode = md; ready = 1'b1;
        if (w8) start8 = 1'b1; else start32 = 1'b1;
        @(negedge clock);
        start8 = 1'b0; start32 = 1'b0;
        while (!term && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (sb !== 1'b1) begin
                    errors++; $display("FAIL busy_after_start: got %b expected 1 (n=%0d)", sb, nn);
                end
            end
            if (rmode == 0 && cyc <= exp_pat.size()) begin
                checks++;
                if (sv !== exp_pat[cyc-1] || sd !== (cyc == exp_pat.size())) begin
                    errors++;
                    $display("FAIL cycle_pattern: cyc %0d got valid=%b done=%b expected valid=%b done=%b (n=%0d mode=%b)",
                             cyc, sv, sd, exp_pat[cyc-1], (cyc == exp_pat.size()), nn, md);
                end
            end
            if (held) begin
                checks++;
                if (sv !== 1'b1 || so !== pout || sd !== pdone || se !== perr) begin
                    errors++;
                    $display("FAIL hold: got valid=%b out=%0d done=%b expected valid=1 out=%0d done=%b",
                             sv, so, sd, pout, pdone);
                end
            end
            k++;
            ready = next_ready(rmode, k);
            if (sv === 1'b1 && ready === 1'b1) begin
                if (sd === 1'b1) begin
                    term = 1;
                    checks++;
                    if (so !== 32'd0 || se !== exp_err || idx != exp_q.size()) begin
                        errors++;
                        $display("FAIL terminal: got out=%0d error=%b beats=%0d expected out=0 error=%b beats=%0d",
                                 so, se, idx, exp_err, exp_q.size());
                    end
                end else begin
                    checks++;
                    if (idx >= exp_q.size()) begin
                        errors++; $display("FAIL data: extra beat %0d expected none", so);
                    end else if (so !== exp_q[idx][31:0]) begin
                        errors++; $display("FAIL data: beat %0d got %0d expected %0d", idx, so, exp_q[idx]);
                    end
                    idx++;
                end
            end
            held = (sv === 1'b1) && (ready !== 1'b1);
            pout = so; pdone = sd; perr = se;
            if (poke != 0 && cyc == poke) begin
                n = 32'd3; mode = 3'b001;
                if (w8) start8 = 1'b1; else start32 = 1'b1;
            end else begin
                start8 = 1'b0; start32 = 1'b0;
            end
        end
        start8 = 1'b0; start32 = 1'b0;
        if (!term) begin
            errors++; $display("FAIL timeout: no terminal beat consumed within %0d cycles", cyc);
        end
        @(negedge clock);
        checks++;
        if (sb !== 1'b0 || sv !== 1'b0) begin
            errors++; $display("FAIL idle_after_term: got busy=%b valid=%b expected 0 0", sb, sv);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({valid32, done32, error32, busy32, out32} !== 36'd0 ||
            {valid8, done8, error8, busy8, out8} !== 12'd0) begin
            errors++; $display("FAIL reset_state: got d32=%b%b%b%b/%0d d8=%b%b%b%b/%0d expected all 0",
                               valid32, done32, error32, busy32, out32, valid8, done8, error8, busy8, out8);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        run_stream(0, 10, 3'b000, 0, 0);
    endtask

    task automatic test_filter();
        run_stream(0, 10, 3'b001, 0, 0);
        run_stream(0, 10, 3'b010, 0, 0);
        run_stream(0, 10, 3'b011, 0, 0);
    endtask

    task automatic test_backpressure();
        run_stream(0, 10, 3'b000, 1, 0);
        run_stream(1, 255, 3'b000, 1, 0);
    endtask

    task automatic test_overflow();
        run_stream(1, 255, 3'b000, 0, 0);
        run_stream(1, 200, 3'b000, 0, 0);
        run_stream(1, 255, 3'b001, 0, 0);
    endtask

    task automatic test_count();
        run_stream(1, 20, 3'b100, 0, 0);
        run_stream(1, 5, 3'b100, 0, 0);
        run_stream(1, 14, 3'b100, 0, 0);
        run_stream(0, 60, 3'b110, 1, 0);
    endtask

    task automatic test_zero();
        run_stream(0, 0, 3'b000, 0, 0);
        run_stream(1, 0, 3'b100, 0, 0);
    endtask

    task automatic test_start_ignored();
        run_stream(0, 10, 3'b000, 0, 3);
    endtask

    task automatic test_mid_reset();
        sel8 = 1'b0;
        @(negedge clock);
        n = 32'd100; mode = 3'b000; ready = 1'b1; start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (valid32 !== 1'b1 || busy32 !== 1'b1) begin
            errors++; $display("FAIL midrun_active: got valid=%b busy=%b expected 1 1", valid32, busy32);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (valid32 !== 1'b0 || done32 !== 1'b0 || busy32 !== 1'b0) begin
            errors++; $display("FAIL async_reset: got valid=%b done=%b busy=%b expected 0 0 0",
                               valid32, done32, busy32);
        end
        @(negedge clock);
        reset = 1'b1;
        run_stream(0, 10, 3'b000, 0, 0);
    endtask

    task automatic test_random();
        bit w8;
        logic [2:0] md;
        longint unsigned nn;
        for (int i = 0; i < 24; i++) begin
            w8 = $urandom_range(0, 1);
            md = 3'($urandom_range(0, 7));
            if (md[2]) nn = $urandom_range(0, w8 ? 20 : 60);
            else       nn = w8 ? $urandom_range(0, 255) : longint'($urandom);
            run_stream(w8, nn, md, $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_filter();
        test_backpressure();
        test_overflow();
        test_count();
        test_zero();
        test_start_ignored();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
